// File: rtl/lsu_wb_master.sv
// rtl/lsu_wb_master.sv - Wishbone B4 classic master behind the LSU, one transfer at a time
module lsu_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_dat_i,
    input  logic [3:0]  lsu_sel_i,
    input  logic        lsu_we_i,
    input  logic        lsu_re_i,
    output logic [31:0] lsu_dat_o,
    output logic        lsu_stall_o,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic        err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] rdat_q, rdat_d;

    logic req;
    logic timeout_hit;

    assign req         = lsu_we_i | lsu_re_i;
    // A zero TIMEOUT_CYCLES turns the abort path off entirely.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdat_d  = rdat_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    adr_d   = lsu_addr_i;
                    dat_d   = lsu_dat_i;
                    we_d    = lsu_we_i;
                    // A read with no lanes selected still fetches the whole word.
                    sel_d   = (!lsu_we_i && lsu_sel_i == 4'h0) ? 4'hF : lsu_sel_i;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cyc_q && wbm_err_i) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cyc_q && wbm_ack_i) begin
                    if (!we_q) begin
                        rdat_d = wbm_dat_i;
                    end
                    cyc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign lsu_stall_o = ((state_q == S_IDLE) && req) || (state_q == S_BUSY);
    assign lsu_done_o  = (state_q == S_DONE);
    assign lsu_err_o   = (state_q == S_DONE) && err_q;
    assign lsu_dat_o   = rdat_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_we_o    = we_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// tb/tb_lsu_wb_master.sv - directed bench for lsu_wb_master (timeout shortened to 4)
module tb_lsu_wb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdat = '0;
    logic [3:0]  lsu_sel = '0;
    logic        lsu_we = 1'b0;
    logic        lsu_re = 1'b0;
    logic [31:0] lsu_rdat;
    logic        stall, done, err;
    logic [31:0] wb_adr, wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_wb_master #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_addr_i(lsu_addr), .lsu_dat_i(lsu_wdat), .lsu_sel_i(lsu_sel),
        .lsu_we_i(lsu_we), .lsu_re_i(lsu_re),
        .lsu_dat_o(lsu_rdat), .lsu_stall_o(stall), .lsu_done_o(done), .lsu_err_o(err),
        .wbm_adr_o(wb_adr), .wbm_dat_o(wb_dat_o), .wbm_sel_o(wb_sel), .wbm_we_o(wb_we),
        .wbm_cyc_o(wb_cyc), .wbm_stb_o(wb_stb),
        .wbm_dat_i(wb_dat_i), .wbm_ack_i(wb_ack), .wbm_err_i(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        lsu_we = we; lsu_re = re; lsu_addr = a; lsu_wdat = d; lsu_sel = s;
    endtask

    initial begin
        // reset
        tick(); tick(); #1;
        chk("rst_cyc", wb_cyc, 0); chk("rst_stb", wb_stb, 0); chk("rst_done", done, 0);
        chk("rst_err", err, 0); chk("rst_stall", stall, 0); chk("rst_rdat", lsu_rdat, 0);
        chk("rst_adr", wb_adr, 0); chk("rst_we", wb_we, 0);
        rst = 1'b1;

        // 1: write, ack in 3rd BUSY cycle
        tick(); drive(1, 0, 32'h100, 32'hDEADBEEF, 4'hF); #1;
        chk("t1_stall_idle", stall, 1); chk("t1_cyc_idle", wb_cyc, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); if (i == 2) wb_ack = 1'b1; #1;
            chk("t1_cyc", wb_cyc, 1); chk("t1_stb", wb_stb, 1); chk("t1_adr", wb_adr, 32'h100);
            chk("t1_dat", wb_dat_o, 32'hDEADBEEF); chk("t1_we", wb_we, 1);
            chk("t1_stall", stall, 1); chk("t1_done_busy", done, 0);
        end
        tick(); wb_ack = 1'b0; drive(0, 0, 0, 0, 0); #1;
        chk("t1_done", done, 1); chk("t1_err", err, 0); chk("t1_stall_done", stall, 0);
        chk("t1_cyc_done", wb_cyc, 0);
        tick(); #1;
        chk("t1_done_once", done, 0);

        // 2: read with immediate ack
        tick(); drive(0, 1, 32'h204, 32'h0, 4'b1100); #1;
        chk("t2_stall_idle", stall, 1);
        tick(); wb_ack = 1'b1; wb_dat_i = 32'h12345678; #1;
        chk("t2_stall_busy", stall, 1); chk("t2_sel", wb_sel, 4'b1100); chk("t2_we", wb_we, 0);
        chk("t2_adr", wb_adr, 32'h204); chk("t2_cyc", wb_cyc, 1);
        tick(); wb_ack = 1'b0; wb_dat_i = '0; drive(0, 0, 0, 0, 0); #1;
        chk("t2_done", done, 1); chk("t2_err", err, 0); chk("t2_rdat", lsu_rdat, 32'h12345678);
        chk("t2_stall_done", stall, 0);

        // 3: read with sel=0 (forced to F), err on 2nd BUSY cycle
        tick(); drive(0, 1, 32'h300, 32'h0, 4'h0); #1;
        tick(); #1;
        chk("t3_sel_forced", wb_sel, 4'hF); chk("t3_cyc", wb_cyc, 1);
        tick(); wb_err = 1'b1; #1;
        chk("t3_cyc2", wb_cyc, 1);
        tick(); wb_err = 1'b0; drive(0, 0, 0, 0, 0); #1;
        chk("t3_done", done, 1); chk("t3_err", err, 1); chk("t3_rdat", lsu_rdat, 32'h12345678);
        chk("t3_cyc_done", wb_cyc, 0); chk("t3_stb_done", wb_stb, 0);

        // 4: timeout after 4 BUSY cycles, late ack ignored
        tick(); drive(0, 1, 32'h400, 32'h0, 4'hF); #1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("t4_cyc", wb_cyc, 1); chk("t4_done_busy", done, 0);
        end
        tick(); drive(0, 0, 0, 0, 0); #1;
        chk("t4_done", done, 1); chk("t4_err", err, 1); chk("t4_cyc_done", wb_cyc, 0);
        tick(); #1;
        tick(); wb_ack = 1'b1; wb_dat_i = 32'hFFFF0000; #1;
        chk("t4_late_cyc", wb_cyc, 0); chk("t4_late_stall", stall, 0);
        tick(); wb_ack = 1'b0; wb_dat_i = '0; #1;
        chk("t4_late_done", done, 0); chk("t4_late_rdat", lsu_rdat, 32'h12345678);
        chk("t4_late_cyc2", wb_cyc, 0);

        // 5: we and re together -> write
        tick(); drive(1, 1, 32'h500, 32'hA5A5A5A5, 4'h3); #1;
        tick(); wb_ack = 1'b1; #1;
        chk("t5_we", wb_we, 1); chk("t5_dat", wb_dat_o, 32'hA5A5A5A5); chk("t5_sel", wb_sel, 4'h3);
        tick(); wb_ack = 1'b0; drive(0, 0, 0, 0, 0); #1;
        chk("t5_done", done, 1); chk("t5_err", err, 0);
        tick(); #1;
        chk("t5_done_once", done, 0); chk("t5_cyc", wb_cyc, 0);

        // ack and err together count as an error, read data not taken
        tick(); drive(0, 1, 32'h700, 32'h0, 4'hF); #1;
        tick(); wb_ack = 1'b1; wb_err = 1'b1; wb_dat_i = 32'h00000BAD; #1;
        tick(); wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0; drive(0, 0, 0, 0, 0); #1;
        chk("t7_done", done, 1); chk("t7_err", err, 1); chk("t7_rdat", lsu_rdat, 32'h12345678);

        // 6: reset during 2nd BUSY cycle
        tick(); drive(1, 0, 32'h800, 32'h55, 4'hF); #1;
        tick(); #1;
        chk("t6_cyc_busy", wb_cyc, 1);
        tick(); rst = 1'b0; #1;
        tick(); rst = 1'b1; drive(0, 0, 0, 0, 0); #1;
        chk("t6_cyc", wb_cyc, 0); chk("t6_stb", wb_stb, 0); chk("t6_done", done, 0);
        chk("t6_err", err, 0); chk("t6_rdat", lsu_rdat, 0); chk("t6_stall", stall, 0);
        tick(); #1;
        chk("t6_no_pulse", done, 0);

        // back-to-back reads after reset
        tick(); drive(0, 1, 32'h600, 32'h0, 4'hF); #1;
        tick(); wb_ack = 1'b1; wb_dat_i = 32'h11111111; #1;
        tick(); wb_ack = 1'b0; wb_dat_i = '0; drive(0, 1, 32'h604, 32'h0, 4'hF); #1;
        chk("b2b_done1", done, 1); chk("b2b_rdat1", lsu_rdat, 32'h11111111);
        chk("b2b_stall_done", stall, 0); chk("b2b_cyc_done", wb_cyc, 0);
        tick(); #1;
        chk("b2b_idle_cyc", wb_cyc, 0); chk("b2b_idle_stall", stall, 1); chk("b2b_idle_done", done, 0);
        tick(); wb_ack = 1'b1; wb_dat_i = 32'h22222222; #1;
        chk("b2b_cyc2", wb_cyc, 1); chk("b2b_adr2", wb_adr, 32'h604);
        tick(); wb_ack = 1'b0; wb_dat_i = '0; drive(0, 0, 0, 0, 0); #1;
        chk("b2b_done2", done, 1); chk("b2b_err2", err, 0); chk("b2b_rdat2", lsu_rdat, 32'h22222222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
